// File: rtl/pcr_amend_front_gen.sv
// PCR front amender for the 1G Ethernet/IPv4/UDP/TS byte stream.
// Finds PCR fields and adds or subtracts a 27 MHz offset at a fixed 6-cycle latency.
module pcr_amend_front_gen #(
   parameter int unsigned ETH_HDR_LEN   = 14,
   parameter int unsigned UDP_HDR_LEN   = 8,
   parameter bit          PID_FILTER_EN = 1'b0,
   parameter logic [5:0]  RSV_VAL       = 6'h3F,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       pcr_din,
   input  logic             pcr_din_en,
   input  logic             good_frame_in,
   input  logic             bad_frame_in,
   input  logic [1:0]       pcr_mode,
   input  logic [12:0]      pcr_pid,
   input  logic [32:0]      pcr_base_cnt,
   input  logic [8:0]       pcr_ext_cnt,
   output logic [7:0]       pcr_dout,
   output logic             pcr_dout_en,
   output logic             good_frame_out,
   output logic             bad_frame_out,
   output logic [CNT_W-1:0] pcr_hit_cnt,
   output logic             pcr_err
);

   typedef enum logic [3:0] {
      StIdle, StH1, StH2, StH3, StAfl, StAff,
      StP0, StP1, StP2, StP3, StP4, StP5, StAmd
   } state_e;

   localparam logic [1:0] ModeSub = 2'b01;
   localparam logic [1:0] ModeAdd = 2'b10;

   state_e           state_q;
   logic [10:0]      byte_idx_q;
   logic [3:0]       ihl_q;
   logic [7:0]       ts_idx_q;
   logic [7:0]       ts_cur;
   logic [10:0]      pay_start;
   logic [12:0]      pid_q;
   logic [32:0]      obase_q;
   logic [8:0]       oext_q;
   logic [1:0]       omode_q;

   // Stage 0 holds the newest byte; stage 5 feeds the output register.
   logic [5:0][7:0]  dat_q;
   logic [5:0]       en_q;
   logic [5:0]       good_q;
   logic [5:0]       bad_q;
   logic [5:0][7:0]  src;

   logic             hdr_hit;
   logic             mode_ok;
   logic             pid_ok;
   logic [32:0]      f_base;
   logic [8:0]       f_ext;
   logic [32:0]      nb;
   logic [8:0]       ne;
   logic [9:0]       e_add;
   logic             carry;
   logic             borrow;
   logic             ext_bad;
   logic             amd_go;
   logic             do_amend;

   // ---------------------------------------------------------------------------------------------
   // Byte and TS position tracking
   // ---------------------------------------------------------------------------------------------
   assign pay_start = 11'(ETH_HDR_LEN) + {5'd0, ihl_q, 2'b00} + 11'(UDP_HDR_LEN);

   always_comb begin
      ts_cur = 8'd0;
      if (pcr_din_en) begin
         if (byte_idx_q == pay_start) begin
            ts_cur = 8'd1;
         end else if (ts_idx_q == 8'd0) begin
            ts_cur = 8'd0;
         end else if (ts_idx_q == 8'd188) begin
            ts_cur = 8'd1;
         end else begin
            ts_cur = ts_idx_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_idx_q <= '0;
         ihl_q      <= '0;
         ts_idx_q   <= '0;
      end else begin
         ts_idx_q <= ts_cur;
         if (!pcr_din_en) begin
            byte_idx_q <= '0;
         end else begin
            if (byte_idx_q != 11'd2047) byte_idx_q <= byte_idx_q + 11'd1;
            if (byte_idx_q == 11'(ETH_HDR_LEN)) ihl_q <= pcr_din[3:0];
         end
      end
   end

   // ---------------------------------------------------------------------------------------------
   // TS header / adaptation field parser
   // ---------------------------------------------------------------------------------------------
   assign hdr_hit = (ts_cur == 8'd1) && (pcr_din == 8'h47);
   assign mode_ok = (pcr_mode == ModeSub) || (pcr_mode == ModeAdd);
   assign pid_ok  = !PID_FILTER_EN || (pid_q == pcr_pid);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         pid_q   <= '0;
         obase_q <= '0;
         oext_q  <= '0;
         omode_q <= '0;
      end else if (!pcr_din_en) begin
         state_q <= StIdle;
      end else begin
         unique case (state_q)
            StIdle: state_q <= hdr_hit ? StH1 : StIdle;
            StH1: begin
               pid_q[12:8] <= pcr_din[4:0];
               state_q     <= StH2;
            end
            StH2: begin
               pid_q[7:0] <= pcr_din;
               state_q    <= StH3;
            end
            StH3:  state_q <= pcr_din[5] ? StAfl : StIdle;
            StAfl: state_q <= (pcr_din >= 8'd7) ? StAff : StIdle;
            StAff: begin
               if (pcr_din[4] && mode_ok && pid_ok) begin
                  obase_q <= pcr_base_cnt;
                  oext_q  <= pcr_ext_cnt;
                  omode_q <= pcr_mode;
                  state_q <= StP0;
               end else begin
                  state_q <= StIdle;
               end
            end
            StP0:  state_q <= StP1;
            StP1:  state_q <= StP2;
            StP2:  state_q <= StP3;
            StP3:  state_q <= StP4;
            StP4:  state_q <= StP5;
            StP5:  state_q <= StAmd;
            StAmd: state_q <= hdr_hit ? StH1 : StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // ---------------------------------------------------------------------------------------------
   // PCR arithmetic on the six bytes sitting in the delay line during AMD
   // ---------------------------------------------------------------------------------------------
   assign f_base  = {dat_q[5], dat_q[4], dat_q[3], dat_q[2], dat_q[1][7]};
   assign f_ext   = {dat_q[1][0], dat_q[0]};
   assign ext_bad = f_ext > 9'd299;
   assign e_add   = {1'b0, f_ext} + {1'b0, oext_q};
   assign carry   = e_add >= 10'd300;
   assign borrow  = f_ext < oext_q;

   // 9-bit wraparound is exact here since every true result is below 300.
   always_comb begin
      if (omode_q == ModeAdd) begin
         nb = f_base + obase_q + {32'd0, carry};
         ne = carry ? (f_ext + oext_q - 9'd300) : e_add[8:0];
      end else begin
         nb = f_base - obase_q - {32'd0, borrow};
         ne = borrow ? (f_ext + 9'd300 - oext_q) : (f_ext - oext_q);
      end
   end

   assign amd_go   = (state_q == StAmd) && pcr_din_en;
   assign do_amend = amd_go && !ext_bad;
   assign src      = do_amend ? {nb, RSV_VAL, ne} : dat_q;

   // ---------------------------------------------------------------------------------------------
   // Delay line, output register, hit counter and error pulse
   // ---------------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dat_q          <= '0;
         en_q           <= '0;
         good_q         <= '0;
         bad_q          <= '0;
         pcr_dout       <= '0;
         pcr_dout_en    <= 1'b0;
         good_frame_out <= 1'b0;
         bad_frame_out  <= 1'b0;
         pcr_hit_cnt    <= '0;
         pcr_err        <= 1'b0;
      end else begin
         dat_q          <= {src[4:0], pcr_din};
         en_q           <= {en_q[4:0], pcr_din_en};
         good_q         <= {good_q[4:0], good_frame_in};
         bad_q          <= {bad_q[4:0], bad_frame_in};
         pcr_dout       <= src[5];
         pcr_dout_en    <= en_q[5];
         good_frame_out <= good_q[5];
         bad_frame_out  <= bad_q[5];
         pcr_err        <= amd_go && ext_bad;
         if (do_amend) pcr_hit_cnt <= pcr_hit_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pcr_amend_front_gen.sv
// Directed bench for pcr_amend_front_gen: one unfiltered and one PID-filtered instance.
module tb_pcr_amend_front_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  pcr_din;
   logic        pcr_din_en;
   logic        good_frame_in;
   logic        bad_frame_in;
   logic [1:0]  pcr_mode;
   logic [12:0] pcr_pid;
   logic [32:0] pcr_base_cnt;
   logic [8:0]  pcr_ext_cnt;

   logic [7:0]  pcr_dout, pf_dout;
   logic        pcr_dout_en, pf_dout_en;
   logic        good_frame_out, pf_good;
   logic        bad_frame_out, pf_bad;
   logic [15:0] pcr_hit_cnt, pf_hit_cnt;
   logic        pcr_err, pf_err;

   pcr_amend_front_gen u_dut (
      .clk(clk), .rst(rst), .pcr_din(pcr_din), .pcr_din_en(pcr_din_en),
      .good_frame_in(good_frame_in), .bad_frame_in(bad_frame_in), .pcr_mode(pcr_mode),
      .pcr_pid(pcr_pid), .pcr_base_cnt(pcr_base_cnt), .pcr_ext_cnt(pcr_ext_cnt),
      .pcr_dout(pcr_dout), .pcr_dout_en(pcr_dout_en), .good_frame_out(good_frame_out),
      .bad_frame_out(bad_frame_out), .pcr_hit_cnt(pcr_hit_cnt), .pcr_err(pcr_err)
   );

   pcr_amend_front_gen #(.PID_FILTER_EN(1'b1)) u_dut_pf (
      .clk(clk), .rst(rst), .pcr_din(pcr_din), .pcr_din_en(pcr_din_en),
      .good_frame_in(good_frame_in), .bad_frame_in(bad_frame_in), .pcr_mode(pcr_mode),
      .pcr_pid(pcr_pid), .pcr_base_cnt(pcr_base_cnt), .pcr_ext_cnt(pcr_ext_cnt),
      .pcr_dout(pf_dout), .pcr_dout_en(pf_dout_en), .good_frame_out(pf_good),
      .bad_frame_out(pf_bad), .pcr_hit_cnt(pf_hit_cnt), .pcr_err(pf_err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  oq[$];
   int          err_pulses;
   int          first_out;
   int          good_cyc;
   int          bad_cyc;
   int          in_start;
   int          end_cyc;
   logic [7:0]  frm[256];
   logic [7:0]  exp_frm[256];
   int          flen = 230;

   always @(negedge clk) begin
      if (pcr_dout_en) begin
         if (oq.size() == 0) first_out = int'(cyc);
         oq.push_back(pcr_dout);
      end
      if (pcr_err) err_pulses++;
      if (good_frame_out) good_cyc = int'(cyc);
      if (bad_frame_out) bad_cyc = int'(cyc);
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Eth(14) + IPv4 IHL=5 (20) + UDP(8) puts the TS sync byte at 42 and the PCR at 48..53.
   task automatic make_frame(input logic [12:0] pid, input logic [32:0] b, input logic [8:0] e,
                             input logic [5:0] rsv, input logic [7:0] afl, input logic [7:0] flg);
      logic [47:0] f;
      for (int i = 0; i < 230; i++) frm[i] = 8'((i * 37 + 11) & 255);
      frm[14] = 8'h45;
      frm[42] = 8'h47;
      frm[43] = {3'b010, pid[12:8]};
      frm[44] = pid[7:0];
      frm[45] = 8'h30;
      frm[46] = afl;
      frm[47] = flg;
      f = {b, rsv, e};
      for (int j = 0; j < 6; j++) frm[48 + j] = f[47 - 8 * j -: 8];
   endtask

   task automatic save_exp();
      for (int i = 0; i < 256; i++) exp_frm[i] = frm[i];
   endtask

   task automatic drive_frame(input int stop_at, input int chg_at, input bit use_bad);
      oq.delete();
      err_pulses = 0;
      good_cyc   = -1;
      bad_cyc    = -1;
      first_out  = -1;
      for (int i = 0; i < flen; i++) begin
         if (i == stop_at) break;
         @(posedge clk);
         #1;
         pcr_din    = frm[i];
         pcr_din_en = 1'b1;
         if (i == 0) in_start = int'(cyc) + 1;
         if (i == flen - 1) begin
            good_frame_in = !use_bad;
            bad_frame_in  = use_bad;
            end_cyc       = int'(cyc) + 1;
         end
         if (i == chg_at) begin
            pcr_base_cnt = 33'h0ABCD;
            pcr_ext_cnt  = 9'd7;
            pcr_mode     = 2'b00;
         end
      end
      @(posedge clk);
      #1;
      pcr_din       = 8'h00;
      pcr_din_en    = 1'b0;
      good_frame_in = 1'b0;
      bad_frame_in  = 1'b0;
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic check_frame(input string tag, input int n);
      int nmis;
      check_val({tag, "_len"}, 64'(oq.size()), 64'(n));
      nmis = 0;
      for (int i = 0; i < n && i < oq.size(); i++) if (oq[i] !== exp_frm[i]) nmis++;
      check_val({tag, "_badbytes"}, 64'(nmis), 64'd0);
      if (n > 53 && oq.size() > 53)
         for (int j = 0; j < 6; j++)
            check_val($sformatf("%s_pcr%0d", tag, j), 64'(oq[48 + j]), 64'(exp_frm[48 + j]));
   endtask

   task automatic set_off(input logic [1:0] m, input logic [32:0] b, input logic [8:0] e);
      pcr_mode     = m;
      pcr_base_cnt = b;
      pcr_ext_cnt  = e;
   endtask

   initial begin
      rst           = 1'b0;
      pcr_din       = 8'h00;
      pcr_din_en    = 1'b0;
      good_frame_in = 1'b0;
      bad_frame_in  = 1'b0;
      pcr_pid       = 13'h100;
      set_off(2'b00, 33'd200, 9'd150);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_dout", 64'(pcr_dout), 64'd0);
      check_val("rst_en", 64'(pcr_dout_en), 64'd0);
      check_val("rst_good", 64'(good_frame_out), 64'd0);
      check_val("rst_bad", 64'(bad_frame_out), 64'd0);
      check_val("rst_hit", 64'(pcr_hit_cnt), 64'd0);
      check_val("rst_err", 64'(pcr_err), 64'd0);
      rst = 1'b1;

      // Bypass
      make_frame(13'h100, 33'd1000, 9'd100, 6'h00, 8'd7, 8'h10);
      save_exp();
      drive_frame(999, -1, 1'b0);
      check_frame("bypass", 230);
      check_val("bypass_lat_en", 64'(first_out - in_start), 64'd6);
      check_val("bypass_lat_good", 64'(good_cyc - end_cyc), 64'd6);
      check_val("bypass_hit", 64'(pcr_hit_cnt), 64'd0);

      // Subtract with borrow; offsets change after the latch point
      set_off(2'b01, 33'd200, 9'd150);
      make_frame(13'h100, 33'd799, 9'd250, 6'h3F, 8'd7, 8'h10);
      save_exp();
      make_frame(13'h100, 33'd1000, 9'd100, 6'h00, 8'd7, 8'h10);
      drive_frame(999, 50, 1'b0);
      check_frame("sub_borrow", 230);
      check_val("sub_lat_en", 64'(first_out - in_start), 64'd6);
      check_val("sub_hit", 64'(pcr_hit_cnt), 64'd1);
      check_val("sub_hit_pf", 64'(pf_hit_cnt), 64'd1);

      // Add with carry and base wrap
      set_off(2'b10, 33'd0, 9'd60);
      make_frame(13'h100, 33'd0, 9'd10, 6'h3F, 8'd7, 8'h10);
      save_exp();
      make_frame(13'h100, 33'h1FFFFFFFF, 9'd250, 6'h00, 8'd7, 8'h10);
      drive_frame(999, -1, 1'b0);
      check_frame("add_wrap", 230);
      check_val("add_wrap_hit", 64'(pcr_hit_cnt), 64'd2);

      // Add without carry
      set_off(2'b10, 33'd1000, 9'd20);
      make_frame(13'h100, 33'd6000, 9'd30, 6'h3F, 8'd7, 8'h10);
      save_exp();
      make_frame(13'h100, 33'd5000, 9'd10, 6'h15, 8'd7, 8'h10);
      drive_frame(999, -1, 1'b0);
      check_frame("add_plain", 230);
      check_val("add_plain_hit", 64'(pcr_hit_cnt), 64'd3);

      // Subtract without borrow, bad end-of-frame strobe
      set_off(2'b01, 33'd1000, 9'd50);
      make_frame(13'h100, 33'd4000, 9'd150, 6'h3F, 8'd7, 8'h10);
      save_exp();
      make_frame(13'h100, 33'd5000, 9'd200, 6'h00, 8'd7, 8'h10);
      drive_frame(999, -1, 1'b1);
      check_frame("sub_plain", 230);
      check_val("sub_plain_lat_bad", 64'(bad_cyc - end_cyc), 64'd6);
      check_val("sub_plain_good", 64'(good_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
      check_val("sub_plain_hit", 64'(pcr_hit_cnt), 64'd4);

      // PID filter: 0x101 passes the filtered instance untouched
      set_off(2'b01, 33'd200, 9'd150);
      make_frame(13'h101, 33'd799, 9'd250, 6'h3F, 8'd7, 8'h10);
      save_exp();
      make_frame(13'h101, 33'd1000, 9'd100, 6'h00, 8'd7, 8'h10);
      drive_frame(999, -1, 1'b0);
      check_frame("pid101", 230);
      check_val("pid101_hit", 64'(pcr_hit_cnt), 64'd5);
      check_val("pid101_hit_pf", 64'(pf_hit_cnt), 64'd4);
      make_frame(13'h100, 33'd799, 9'd250, 6'h3F, 8'd7, 8'h10);
      save_exp();
      make_frame(13'h100, 33'd1000, 9'd100, 6'h00, 8'd7, 8'h10);
      drive_frame(999, -1, 1'b0);
      check_frame("pid100", 230);
      check_val("pid100_hit_pf", 64'(pf_hit_cnt), 64'd5);

      // Illegal ext: unmodified, one error pulse
      make_frame(13'h100, 33'd1000, 9'd350, 6'h00, 8'd7, 8'h10);
      save_exp();
      drive_frame(999, -1, 1'b0);
      check_frame("ext_bad", 230);
      check_val("ext_bad_err", 64'(err_pulses), 64'd1);
      check_val("ext_bad_hit", 64'(pcr_hit_cnt), 64'd6);

      // AF length 0, then PCR flag clear
      make_frame(13'h100, 33'd1000, 9'd100, 6'h00, 8'd0, 8'h10);
      save_exp();
      drive_frame(999, -1, 1'b0);
      check_frame("afl0", 230);
      make_frame(13'h100, 33'd1000, 9'd100, 6'h00, 8'd7, 8'h00);
      save_exp();
      drive_frame(999, -1, 1'b0);
      check_frame("noflag", 230);
      check_val("noflag_hit", 64'(pcr_hit_cnt), 64'd6);
      check_val("noflag_err", 64'(err_pulses), 64'd0);

      // Abort: en drops on P3
      make_frame(13'h100, 33'd1000, 9'd100, 6'h00, 8'd7, 8'h10);
      save_exp();
      drive_frame(51, -1, 1'b0);
      check_frame("abort", 51);
      check_val("abort_hit", 64'(pcr_hit_cnt), 64'd6);
      make_frame(13'h100, 33'd799, 9'd250, 6'h3F, 8'd7, 8'h10);
      save_exp();
      make_frame(13'h100, 33'd1000, 9'd100, 6'h00, 8'd7, 8'h10);
      drive_frame(999, -1, 1'b0);
      check_frame("post_abort", 230);
      check_val("post_abort_hit", 64'(pcr_hit_cnt), 64'd7);

      // Reset mid-frame, then a clean amended frame
      for (int i = 0; i < 49; i++) begin
         @(posedge clk);
         #1;
         pcr_din    = frm[i];
         pcr_din_en = 1'b1;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_val("mrst_dout", 64'(pcr_dout), 64'd0);
      check_val("mrst_en", 64'(pcr_dout_en), 64'd0);
      check_val("mrst_hit", 64'(pcr_hit_cnt), 64'd0);
      check_val("mrst_hit_pf", 64'(pf_hit_cnt), 64'd0);
      pcr_din_en = 1'b0;
      pcr_din    = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      make_frame(13'h100, 33'd799, 9'd250, 6'h3F, 8'd7, 8'h10);
      save_exp();
      make_frame(13'h100, 33'd1000, 9'd100, 6'h00, 8'd7, 8'h10);
      drive_frame(999, -1, 1'b0);
      check_frame("post_rst", 230);
      check_val("post_rst_lat_en", 64'(first_out - in_start), 64'd6);
      check_val("post_rst_hit", 64'(pcr_hit_cnt), 64'd1);
      check_val("post_rst_hit_pf", 64'(pf_hit_cnt), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
